// File: rtl/fifo_v2_pkg.sv
// Shared types and helpers for the fifo_v2 first-word-fall-through FIFO.
// Optional high-water-mark register is enabled with FIFO_V2_HWM_EN (see fifo_v2.sv).
package fifo_v2_pkg;

   typedef struct packed {
      logic empty;
      logic full;
      logic almost_empty;
      logic almost_full;
      logic overflow;
      logic underflow;
   } fifo_status_t;

   // Modulo increment; the wrap is explicit so DEPTH need not be a power of 2.
   function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_v2_ram.sv
// Simple dual-port RAM with registered read and write-first bypass on address collision.
module fifo_v2_ram #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      // A write landing on the slot being fetched must be visible immediately.
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
   end

endmodule

// File: rtl/fifo_v2.sv
// First-word-fall-through FIFO control: pointers, occupancy, status and sticky errors.
// Define FIFO_V2_HWM_EN to build the high-water-mark register; otherwise hwm reads 0.
module fifo_v2
   import fifo_v2_pkg::*;
#(
   parameter int unsigned WIDTH              = 32,
   parameter int unsigned DEPTH              = 16,
   parameter int unsigned ALMOST_FULL_COUNT  = DEPTH,
   parameter int unsigned ALMOST_EMPTY_COUNT = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   input  logic                       flush,
   input  logic                       err_clr,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_empty,
   output logic                       almost_full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [$clog2(DEPTH+1)-1:0] space,
   output logic                       overflow,
   output logic                       underflow,
   output logic [$clog2(DEPTH+1)-1:0] hwm
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = cnt_width(DEPTH);

   localparam fifo_status_t ST_RST = '{
      empty:        1'b1,
      full:         1'b0,
      almost_empty: 1'b1,
      almost_full:  (ALMOST_FULL_COUNT == 0),
      overflow:     1'b0,
      underflow:    1'b0
   };

   logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [CW-1:0] count_q, space_q, next_count;
   fifo_status_t  st_q, st_d;
   logic          valid_wr, valid_rd, ovf_evt, unf_evt;

   // flush swallows both requests and any error they would have raised
   assign valid_wr = wr_en & ~st_q.full  & ~flush;
   assign valid_rd = rd_en & ~st_q.empty & ~flush;
   assign ovf_evt  = wr_en & st_q.full   & ~flush;
   assign unf_evt  = rd_en & st_q.empty  & ~flush;

   always_comb begin
      next_count = count_q;
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      if (flush) begin
         next_count = '0;
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
      end else begin
         case ({valid_wr, valid_rd})
            2'b10:   next_count = count_q + 1'b1;
            2'b01:   next_count = count_q - 1'b1;
            default: next_count = count_q;
         endcase
         if (valid_wr) wr_ptr_nxt = AW'(wrap_inc(32'(wr_ptr), DEPTH));
         if (valid_rd) rd_ptr_nxt = AW'(wrap_inc(32'(rd_ptr), DEPTH));
      end
   end

   always_comb begin
      st_d              = ST_RST;
      st_d.empty        = (next_count == '0);
      st_d.full         = (next_count == CW'(DEPTH));
      st_d.almost_empty = (32'(next_count) <= ALMOST_EMPTY_COUNT);
      st_d.almost_full  = (32'(next_count) >= ALMOST_FULL_COUNT);
      st_d.overflow     = (st_q.overflow  & ~err_clr) | ovf_evt;
      st_d.underflow    = (st_q.underflow & ~err_clr) | unf_evt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         space_q <= CW'(DEPTH);
         st_q    <= ST_RST;
      end else begin
         wr_ptr  <= wr_ptr_nxt;
         rd_ptr  <= rd_ptr_nxt;
         count_q <= next_count;
         space_q <= CW'(DEPTH) - next_count;
         st_q    <= st_d;
      end
   end

   // Fetch address is the post-pop head so rd_data is ready the following cycle.
   fifo_v2_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (valid_wr & rst_n),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr_nxt),
      .rdata (rd_data)
   );

`ifdef FIFO_V2_HWM_EN
   logic [CW-1:0] hwm_q;

   always_ff @(posedge clk) begin
      if (!rst_n || flush)        hwm_q <= '0;
      else if (next_count > hwm_q) hwm_q <= next_count;
   end

   assign hwm = hwm_q;
`else
   assign hwm = '0;
`endif

   assign empty        = st_q.empty;
   assign full         = st_q.full;
   assign almost_empty = st_q.almost_empty;
   assign almost_full  = st_q.almost_full;
   assign overflow     = st_q.overflow;
   assign underflow    = st_q.underflow;
   assign count        = count_q;
   assign space        = space_q;

endmodule

// File: tb/tb_fifo_v2.sv
// Self-checking bench for fifo_v2 (WIDTH=8, DEPTH=5, almost thresholds 4/1) against a queue model.
module tb_fifo_v2;

   localparam int DEPTH = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, err_clr = 1'b0;
   logic [7:0] wr_data = '0;
   logic [7:0] rd_data;
   logic       empty, full, almost_empty, almost_full, overflow, underflow;
   logic [2:0] count, space, hwm;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [7:0] q[$];
   bit         m_ovf, m_unf;
   int         m_hwm;

   fifo_v2 #(
      .WIDTH(8), .DEPTH(DEPTH), .ALMOST_FULL_COUNT(4), .ALMOST_EMPTY_COUNT(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .flush(flush), .err_clr(err_clr), .empty(empty), .full(full),
      .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
      .space(space), .overflow(overflow), .underflow(underflow), .hwm(hwm)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic int exp_hwm();
`ifdef FIFO_V2_HWM_EN
      return m_hwm;
`else
      return 0;
`endif
   endfunction

   // One clock with the given inputs; the model advances on the same edge.
   task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                      input logic f = 1'b0, input logic ec = 1'b0, input logic rs = 1'b1);
      bit was_full, was_empty;
      wr_en = w; wr_data = d; rd_en = r; flush = f; err_clr = ec; rst_n = rs;
      @(posedge clk);
      if (!rs) begin
         q.delete(); m_ovf = 0; m_unf = 0; m_hwm = 0;
      end else if (f) begin
         q.delete(); m_hwm = 0;
         if (ec) begin m_ovf = 0; m_unf = 0; end
      end else begin
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         if (r && !was_empty) void'(q.pop_front());
         if (w && !was_full)  q.push_back(d);
         m_ovf = (m_ovf && !ec) || (w && was_full);
         m_unf = (m_unf && !ec) || (r && was_empty);
         if (q.size() > m_hwm) m_hwm = q.size();
      end
      #1;
      wr_en = 0; rd_en = 0; flush = 0; err_clr = 0; rst_n = 1;
   endtask

   task automatic test_reset();
      cyc(0, 0, 0, 0, 0, 0);
      n_tests++;
      if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 101000",
                  {empty, full, almost_empty, almost_full, overflow, underflow});
      end
      n_tests++;
      if (count !== 3'd0 || space !== 3'd5 || hwm !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_counts: got count=%0d space=%0d hwm=%0d want 0/5/0", count, space, hwm);
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 5; i++) begin
         cyc(1, 8'(i), 0);
         n_tests++;
         if (count !== 3'(i) || almost_empty !== (i <= 1) || almost_full !== (i >= 4)) begin
            n_fail++;
            $display("FAIL fill_thresh: count=%0d ae=%b af=%b want count=%0d ae=%b af=%b",
                     count, almost_empty, almost_full, i, (i <= 1), (i >= 4));
         end
      end
      n_tests++;
      if (full !== 1'b1 || space !== 3'd0) begin
         n_fail++;
         $display("FAIL fill_full: full=%b space=%0d want 1/0", full, space);
      end
      cyc(1, 8'h06, 0);
      n_tests++;
      if (overflow !== 1'b1 || count !== 3'd5) begin
         n_fail++;
         $display("FAIL fill_overflow: ovf=%b count=%0d want 1/5", overflow, count);
      end
      for (int i = 1; i <= 5; i++) begin
         n_tests++;
         if (rd_data !== 8'(i)) begin
            n_fail++;
            $display("FAIL drain_order: got %h want %h", rd_data, 8'(i));
         end
         cyc(0, 0, 1);
      end
      n_tests++;
      if (empty !== 1'b1 || almost_empty !== 1'b1 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL drain_empty: empty=%b ae=%b count=%0d want 1/1/0", empty, almost_empty, count);
      end
      cyc(0, 0, 0, 0, 1);
   endtask

   task automatic test_latency_underflow();
      cyc(1, 8'hAA, 0);
      n_tests++;
      if (empty !== 1'b0 || rd_data !== 8'hAA) begin
         n_fail++;
         $display("FAIL fwft_latency: empty=%b rd_data=%h want 0/aa", empty, rd_data);
      end
      cyc(0, 0, 1);
      cyc(1, 8'h55, 1);
      n_tests++;
      if (underflow !== 1'b1 || count !== 3'd1 || rd_data !== 8'h55) begin
         n_fail++;
         $display("FAIL empty_wr_rd: unf=%b count=%0d rd=%h want 1/1/55", underflow, count, rd_data);
      end
      cyc(0, 0, 1, 0, 1);
      n_tests++;
      if (underflow !== 1'b0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL unf_clear: unf=%b empty=%b want 0/1", underflow, empty);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] nxt = 8'h10, exp_rd = 8'h10;
      cyc(1, nxt, 0); nxt++;
      cyc(1, nxt, 0); nxt++;
      for (int i = 0; i < 12; i++) begin
         n_tests++;
         if (rd_data !== exp_rd || count !== 3'd2) begin
            n_fail++;
            $display("FAIL wrap_stream: rd=%h count=%0d want %h/2", rd_data, count, exp_rd);
         end
         cyc(1, nxt, 1); nxt++; exp_rd++;
      end
      for (int i = 0; i < 2; i++) begin
         n_tests++;
         if (rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL wrap_tail: rd=%h want %h", rd_data, exp_rd);
         end
         cyc(0, 0, 1); exp_rd++;
      end
      n_tests++;
      if (overflow !== 1'b0 || underflow !== 1'b0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_flags: ovf=%b unf=%b empty=%b want 0/0/1", overflow, underflow, empty);
      end
   endtask

   task automatic test_overflow_errclr();
      for (int i = 1; i <= 5; i++) cyc(1, 8'(8'h20 + i), 0);
      cyc(1, 8'hEE, 1);
      n_tests++;
      if (count !== 3'd4 || full !== 1'b0 || overflow !== 1'b1 || rd_data !== 8'h22) begin
         n_fail++;
         $display("FAIL full_wr_rd: count=%0d full=%b ovf=%b rd=%h want 4/0/1/22",
                  count, full, overflow, rd_data);
      end
      cyc(0, 0, 0, 0, 1);
      n_tests++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clr: ovf=%b want 0", overflow);
      end
      cyc(1, 8'h26, 0);
      cyc(1, 8'h27, 0, 0, 1);
      n_tests++;
      if (overflow !== 1'b1 || count !== 3'd5) begin
         n_fail++;
         $display("FAIL err_clr_vs_event: ovf=%b count=%0d want 1/5", overflow, count);
      end
   endtask

   task automatic test_flush();
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 6; i++) cyc(1, 8'(8'h30 + i), 0);
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc(1, 8'(8'h40 + i), 0);
      n_tests++;
      if (count !== 3'd3 || overflow !== 1'b1 || hwm !== 3'(exp_hwm())) begin
         n_fail++;
         $display("FAIL pre_flush: count=%0d ovf=%b hwm=%0d want 3/1/%0d", count, overflow, hwm, exp_hwm());
      end
      cyc(1, 8'h99, 0, 1);
      n_tests++;
      if (count !== 3'd0 || space !== 3'd5 || empty !== 1'b1 || overflow !== 1'b1 ||
          hwm !== 3'(exp_hwm())) begin
         n_fail++;
         $display("FAIL flush: count=%0d space=%0d empty=%b ovf=%b hwm=%0d want 0/5/1/1/%0d",
                  count, space, empty, overflow, hwm, exp_hwm());
      end
      cyc(0, 0, 0, 0, 1);
   endtask

   task automatic test_reset_mid();
      cyc(1, 8'h11, 0);
      cyc(1, 8'h12, 0);
      cyc(1, 8'h13, 1);
      cyc(1, 8'h14, 1, 0, 0, 0);
      n_tests++;
      if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000 ||
          count !== 3'd0 || space !== 3'd5 || hwm !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_mid: flags=%b count=%0d space=%0d hwm=%0d want 101000/0/5/0",
                  {empty, full, almost_empty, almost_full, overflow, underflow}, count, space, hwm);
      end
   endtask

   task automatic test_random();
      logic [5:0] exp_flags;
      int         sz;
      for (int n = 0; n < 800; n++) begin
         cyc($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
             $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5, $urandom_range(0, 199) != 0);
         sz = q.size();
         exp_flags = {sz == 0, sz == DEPTH, sz <= 1, sz >= 4, m_ovf, m_unf};
         n_tests++;
         if ({empty, full, almost_empty, almost_full, overflow, underflow} !== exp_flags) begin
            n_fail++;
            $display("FAIL rand_flags[%0d]: got %b want %b", n,
                     {empty, full, almost_empty, almost_full, overflow, underflow}, exp_flags);
         end
         n_tests++;
         if (count !== 3'(sz) || space !== 3'(DEPTH - sz) || hwm !== 3'(exp_hwm())) begin
            n_fail++;
            $display("FAIL rand_counts[%0d]: count=%0d space=%0d hwm=%0d want %0d/%0d/%0d",
                     n, count, space, hwm, sz, DEPTH - sz, exp_hwm());
         end
         if (sz != 0) begin
            n_tests++;
            if (rd_data !== q[0]) begin
               n_fail++;
               $display("FAIL rand_data[%0d]: got %h want %h", n, rd_data, q[0]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_latency_underflow();
      test_wrap();
      test_overflow_errclr();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
